// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the zero-register id, write-source codes and the buffered request type.
package wb_write_arbiter_pkg;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam logic       RF_SRC_PIPE = 1'b0;
    localparam logic       RF_SRC_MC   = 1'b1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO of multi-cycle results with per-entry live bits.
// Ports: push/push_req/push_live in, pop in, kill/kill_reg in (clears live on
// every entry whose register matches), head/head_live/count/empty/full out.
import wb_write_arbiter_pkg::*;

module wb_result_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       push_live,
    input  wb_req_t                    push_req,
    input  logic                       pop,
    input  logic                       kill,
    input  logic [4:0]                 kill_reg,
    output wb_req_t                    head,
    output logic                       head_live,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_req_t          mem [DEPTH];
    logic [DEPTH-1:0] live;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign head      = mem[rptr];
    assign head_live = live[rptr];
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live  <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && mem[i].rd == kill_reg) begin
                    live[i] <= 1'b0;
                end
            end
            // The push slot is never occupied, so this cannot undo a kill.
            if (push) begin
                live[wptr] <= push_live;
                wptr       <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Shares the register-file write port between pipeline writeback and a
// multi-cycle result stream; pipeline first, starved results force a bubble.
// Ports: pipe_* and mc_* request inputs, mc_ready/pipe_stall handshakes,
// registered rf_we/rf_waddr/rf_wdata/rf_src, fifo_count, sticky arb_conflict.
import wb_write_arbiter_pkg::*;

module wb_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pipe_reg_write,
    input  logic [4:0]                  pipe_write_reg,
    input  logic [31:0]                 pipe_write_data,
    input  logic                        mc_valid,
    output logic                        mc_ready,
    input  logic [4:0]                  mc_write_reg,
    input  logic [31:0]                 mc_write_data,
    output logic                        pipe_stall,
    output logic                        rf_we,
    output logic [4:0]                  rf_waddr,
    output logic [31:0]                 rf_wdata,
    output logic                        rf_src,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        arb_conflict
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    wb_req_t       head;
    wb_req_t       push_req;
    logic          head_live;
    logic          empty;
    logic          full;
    logic          eff_pipe;
    logic          grant_pipe;
    logic          pop;
    logic          push;
    logic          push_live;
    logic          conflict;
    logic [SW-1:0] starve;

    assign eff_pipe   = pipe_reg_write && (pipe_write_reg != REG_ZERO);
    assign mc_ready   = !full;
    // r0 results are accepted on the handshake but never stored.
    assign push       = mc_valid && mc_ready && (mc_write_reg != REG_ZERO);
    assign pop        = !empty && (pipe_stall || !eff_pipe);
    assign grant_pipe = eff_pipe && !pop;
    assign conflict   = eff_pipe && pipe_stall;
    // A same-cycle pipeline write to the same register is younger.
    assign push_live  = !(grant_pipe && (mc_write_reg == pipe_write_reg));
    assign push_req   = '{rd: mc_write_reg, data: mc_write_data};

    wb_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_live (push_live),
        .push_req  (push_req),
        .pop       (pop),
        .kill      (grant_pipe),
        .kill_reg  (pipe_write_reg),
        .head      (head),
        .head_live (head_live),
        .count     (fifo_count),
        .empty     (empty),
        .full      (full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            rf_src       <= RF_SRC_PIPE;
            starve       <= '0;
            pipe_stall   <= 1'b0;
            arb_conflict <= 1'b0;
        end else begin
            if (pop) begin
                rf_we    <= head_live;
                rf_waddr <= head.rd;
                rf_wdata <= head.data;
                rf_src   <= RF_SRC_MC;
            end else if (grant_pipe) begin
                rf_we    <= 1'b1;
                rf_waddr <= pipe_write_reg;
                rf_wdata <= pipe_write_data;
                rf_src   <= RF_SRC_PIPE;
            end else begin
                rf_we <= 1'b0;
            end

            if (empty || pop) begin
                starve <= '0;
            end else if (starve != LIM) begin
                starve <= starve + 1'b1;
            end

            if (pop) begin
                pipe_stall <= 1'b0;
            end else if (starve == LIM) begin
                pipe_stall <= 1'b1;
            end

            if (conflict) begin
                arb_conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter.
// Drives inputs 1ns after each rising edge and checks registered outputs there.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_reg_write;
    logic [4:0]  pipe_write_reg;
    logic [31:0] pipe_write_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_write_reg;
    logic [31:0] mc_write_data;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_src;
    logic [1:0]  fifo_count;
    logic        arb_conflict;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_write_arbiter #(
        .FIFO_DEPTH  (2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_reg_write (pipe_reg_write),
        .pipe_write_reg (pipe_write_reg),
        .pipe_write_data(pipe_write_data),
        .mc_valid       (mc_valid),
        .mc_ready       (mc_ready),
        .mc_write_reg   (mc_write_reg),
        .mc_write_data  (mc_write_data),
        .pipe_stall     (pipe_stall),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .rf_src         (rf_src),
        .fifo_count     (fifo_count),
        .arb_conflict   (arb_conflict)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] r,
                        input logic [31:0] d);
        pipe_reg_write  = we;
        pipe_write_reg  = r;
        pipe_write_data = d;
    endtask

    task automatic mc(input logic v, input logic [4:0] r,
                      input logic [31:0] d);
        mc_valid      = v;
        mc_write_reg  = r;
        mc_write_data = d;
    endtask

    task automatic idle();
        pipe(1'b0, 5'd0, 32'd0);
        mc(1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #12;
        chk("rst_we", rf_we, 0);
        chk("rst_ready", mc_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_stall", pipe_stall, 0);
        chk("rst_conf", arb_conflict, 0);
        chk("rst_src", rf_src, 0);
        chk("rst_addr", rf_waddr, 0);
        chk("rst_data", rf_wdata, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single mc result with pipeline idle.
        mc(1'b1, 5'd5, 32'h1234);
        step();
        chk("t2_cnt1", fifo_count, 1);
        chk("t2_we0", rf_we, 0);
        idle();
        step();
        chk("t2_we", rf_we, 1);
        chk("t2_addr", rf_waddr, 5);
        chk("t2_data", rf_wdata, 32'h1234);
        chk("t2_src", rf_src, 1);
        chk("t2_cnt0", fifo_count, 0);
        step();
        chk("t2_we_after", rf_we, 0);

        // Starvation behind continuous pipeline writes.
        pipe(1'b1, 5'd1, 32'd1);
        mc(1'b1, 5'd9, 32'h9999);
        step();
        chk("t3_r1", rf_waddr, 1);
        chk("t3_cnt", fifo_count, 1);
        mc(1'b0, 5'd0, 32'd0);
        for (int i = 2; i <= 5; i++) begin
            pipe(1'b1, 5'(i), 32'(i));
            step();
        end
        chk("t3_r5", rf_waddr, 5);
        chk("t3_nostall", pipe_stall, 0);
        pipe(1'b1, 5'd6, 32'd6);
        step();
        chk("t3_r6", rf_waddr, 6);
        chk("t3_r6data", rf_wdata, 6);
        chk("t3_stall", pipe_stall, 1);
        pipe(1'b0, 5'd0, 32'd0);
        step();
        chk("t3_mc_we", rf_we, 1);
        chk("t3_mc_addr", rf_waddr, 9);
        chk("t3_mc_data", rf_wdata, 32'h9999);
        chk("t3_mc_src", rf_src, 1);
        chk("t3_stall0", pipe_stall, 0);
        chk("t3_cnt0", fifo_count, 0);
        pipe(1'b1, 5'd7, 32'd7);
        step();
        chk("t3_r7", rf_waddr, 7);
        chk("t3_r7src", rf_src, 0);
        pipe(1'b1, 5'd8, 32'd8);
        step();
        chk("t3_r8", rf_waddr, 8);
        chk("t3_conf", arb_conflict, 0);

        // WAW kill of the FIFO head, full FIFO backpressure.
        pipe(1'b1, 5'd10, 32'hA);
        mc(1'b1, 5'd7, 32'h7777);
        step();
        chk("t4_cnt1", fifo_count, 1);
        pipe(1'b1, 5'd11, 32'hB);
        mc(1'b1, 5'd3, 32'h3333);
        step();
        chk("t4_cnt2", fifo_count, 2);
        chk("t4_full", mc_ready, 0);
        pipe(1'b1, 5'd7, 32'h70);
        mc(1'b1, 5'd12, 32'hC);
        step();
        chk("t4_pw_addr", rf_waddr, 7);
        chk("t4_pw_data", rf_wdata, 32'h70);
        chk("t4_pw_src", rf_src, 0);
        chk("t4_cnt_full", fifo_count, 2);
        idle();
        step();
        chk("t4_killed_we", rf_we, 0);
        chk("t4_cnt_k", fifo_count, 1);
        step();
        chk("t4_r3_we", rf_we, 1);
        chk("t4_r3_addr", rf_waddr, 3);
        chk("t4_r3_data", rf_wdata, 32'h3333);
        chk("t4_r3_src", rf_src, 1);
        chk("t4_cnt0", fifo_count, 0);
        step();
        chk("t4_no_r12", rf_we, 0);

        // Writes to r0 from both sources are idle.
        pipe(1'b1, 5'd0, 32'hDEAD);
        mc(1'b1, 5'd0, 32'hBEEF);
        step();
        chk("t5_we", rf_we, 0);
        chk("t5_cnt", fifo_count, 0);
        idle();
        step();
        chk("t5_we2", rf_we, 0);
        chk("t5_cnt2", fifo_count, 0);

        // Contract violation while pipe_stall is high.
        pipe(1'b1, 5'd1, 32'd1);
        mc(1'b1, 5'd20, 32'h2020);
        step();
        mc(1'b0, 5'd0, 32'd0);
        for (int i = 2; i <= 6; i++) begin
            pipe(1'b1, 5'(i), 32'(i));
            step();
        end
        chk("t6_stall", pipe_stall, 1);
        pipe(1'b1, 5'd21, 32'hBAD0);
        step();
        chk("t6_conf", arb_conflict, 1);
        chk("t6_we", rf_we, 1);
        chk("t6_addr", rf_waddr, 20);
        chk("t6_data", rf_wdata, 32'h2020);
        chk("t6_src", rf_src, 1);
        chk("t6_stall0", pipe_stall, 0);
        idle();
        step();
        chk("t6_sticky", arb_conflict, 1);
        chk("t6_idle_we", rf_we, 0);

        // Reset with two results buffered.
        pipe(1'b1, 5'd1, 32'd1);
        mc(1'b1, 5'd22, 32'h22);
        step();
        pipe(1'b1, 5'd2, 32'd2);
        mc(1'b1, 5'd23, 32'h23);
        step();
        chk("t1_cnt2", fifo_count, 2);
        idle();
        #2 reset = 1'b0;
        #1;
        chk("t1_cnt", fifo_count, 0);
        chk("t1_ready", mc_ready, 1);
        chk("t1_stall", pipe_stall, 0);
        chk("t1_conf", arb_conflict, 0);
        step();
        chk("t1_we", rf_we, 0);
        reset = 1'b1;
        step();
        chk("t1_we_post", rf_we, 0);
        chk("t1_cnt_post", fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Shares the single register-file write port between the pipeline writeback path and a multi-cycle unit (divider/multiplier) result stream.
- Pipeline writes have priority. Multi-cycle results are buffered in a small FIFO.
- Starvation is resolved by requesting a one-cycle writeback bubble from the hazard unit.
- Sits between the writeback stage outputs and the register file write port.

Parameters:
- FIFO_DEPTH, 2, number of buffered multi-cycle results (power of two, ≥2).
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may wait before pipe_stall is raised (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pipe_reg_write  in  1  pipeline writeback write enable.
- pipe_write_reg  in  5  pipeline destination register.
- pipe_write_data  in  32  pipeline writeback data.
- mc_valid  in  1  multi-cycle result valid.
- mc_ready  out  1  FIFO can accept a result this cycle.
- mc_write_reg  in  5  multi-cycle destination register.
- mc_write_data  in  32  multi-cycle result data.
- pipe_stall  out  1  request to hazard unit: bubble writeback next cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).
- rf_src  out  1  source of current write: 0 = pipeline, 1 = multi-cycle.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- arb_conflict  out  1  sticky error: pipeline write seen while pipe_stall=1.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0 except mc_ready=1.
  - FIFO emptied; starve counter 0; arb_conflict cleared.
  - Reset mid-operation discards all buffered results.
- Latency: a grant in cycle N appears on rf_* at the rising edge ending cycle N. Registered outputs; one write per cycle maximum.
- Effective pipeline request: pipe_reg_write=1 and pipe_write_reg≠0. Writes to r0 are treated as idle.
- Enqueue:
  - mc_valid && mc_ready → entry {reg, data, live=1} is pushed.
  - mc_write_reg=0 is accepted but not pushed (dropped).
- mc_ready = (fifo_count < FIFO_DEPTH), computed from current occupancy only. A pop in the same cycle does not free space for a full-FIFO push.
- Grant priority each cycle:
  1. pipe_stall=1 and FIFO non-empty → pop head.
  2. Effective pipeline request → write pipeline.
  3. FIFO non-empty → pop head.
  4. Otherwise rf_we=0 next cycle.
- Head pop: if head live=1, rf_we=1, rf_src=1, addr/data from head. If live=0 (killed), the pop consumes the slot with rf_we=0.
- WAW kill: when a pipeline write to R is granted, every FIFO entry with reg=R is marked live=0. An mc push to R in the same cycle is also killed (pushed with live=0). The multi-cycle result is older.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped; saturates at STARVE_LIMIT.
  - Clears on head pop or when the FIFO is empty.
- pipe_stall: registered.
  - Set the cycle after the counter reaches STARVE_LIMIT.
  - Held until the head pop occurs; cleared on the edge that registers that pop.
- Contract: the pipeline presents no effective request while pipe_stall=1. A violation sets arb_conflict (sticky until reset); the pipeline write is dropped and the head is still popped.
- fifo_count updates on the same edge as push/pop. Simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package holds:
  - REG_ZERO=5'd0.
  - RF_SRC_PIPE/RF_SRC_MC constants.
  - Packed typedef wb_req_t {reg[4:0], data[31:0]}.
- One natural sub-module: wb_result_fifo (storage, live bits, pointers, count, kill-by-register compare).
- Arbitration, starve counter and output registers stay in the top module.

Test Plan:
1. Reset asserted mid-burst with 2 entries queued → next cycle rf_we=0, fifo_count=0, mc_ready=1, pipe_stall=0.
2. Pipeline idle; mc pushes {r5, 0x1234} → cycle after push, rf_we=1, rf_waddr=5, rf_wdata=0x1234, rf_src=1.
3. Continuous pipeline writes to r1..r8; one mc result to r9 queued → counter hits 4, pipe_stall=1. Bench bubbles WB; r9 written with rf_src=1; pipe_stall drops the following cycle.
4. mc pushes r7 and r3 (FIFO full, mc_ready=0); a further mc_valid is not accepted → a pipeline write to r7 kills the head, the head slot passes with rf_we=0, then r3 is written.
5. Pipeline write to r0 with data 0xDEAD plus an mc push to r0 → no rf_we ever asserted; fifo_count stays 0.
6. Pipeline write asserted while pipe_stall=1 → arb_conflict=1 (sticky until reset), the FIFO head is written, the pipeline data is never written.
